cam_capture: RTL and testbench

Upstream capture stage for the display path. Takes an 8-bit RGB565 camera stream of 640×480 (two bytes per pixel), decimates it 2:1 in both axes to 320×240, reduces each kept pixel to 3-bit {R,G,B}, and emits linear-address write strobes into the 76800×3 frame buffer that the VGA read side scans at addr = y*320 + x. Camera signals arrive already synchronised into the 25 MHz `clk` domain, qualified by a one-cycle `cam_pclk_en` strobe.

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_edge_det.sv | 27 ++
 rtl/cam_capture.sv | 144 ++++++++++++++
 tb/tb_cam_capture.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path.
// Frame buffer geometry and RGB565 -> RGB111 bit selection live here.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        SYNC    = 2'd1,
        ACTIVE  = 2'd2
    } cap_state_t;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int FB_DEPTH = FB_W * FB_H;

    // R from the first (high) byte, G from the first byte, B from the second (low) byte
    localparam int R_BIT = 7;
    localparam int G_BIT = 2;
    localparam int B_BIT = 4;

endpackage

// File: rtl/cam_edge_det.sv
// Strobe-qualified edge detector: compares the signal against its value
// at the previous strobe, so edges are only reported on strobe cycles.
module cam_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= RESET_VAL;
        end else if (strobe) begin
            prev <= sig;
        end
    end

    assign rise = strobe &  sig & ~prev;
    assign fall = strobe & ~sig &  prev;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: RGB565 byte stream in, 2:1 decimated RGB111 frame buffer
// writes out at linear address y*(SRC_W/2)+x.
//
//   state   | meaning
//   WAIT_VS | after reset, waiting for the first vsync rising edge
//   SYNC    | vertical blanking, decide capture on vsync falling edge
//   ACTIVE  | capturing lines until the next vsync rising edge
module cam_capture
    import cam_pkg::*;
#(
    parameter int SRC_W  = 2 * FB_W,
    parameter int SRC_H  = 2 * FB_H,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              cam_pclk_en,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err
);

    // One spare bit so oversized lines/frames saturate above the limits
    localparam int COL_W = $clog2(SRC_W + 1) + 1;
    localparam int ROW_W = $clog2(SRC_H + 1) + 1;
    localparam logic [COL_W-1:0] COL_LIM = COL_W'(SRC_W);
    localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(SRC_H);

    cap_state_t        state, state_nx;
    logic              vs_rise, vs_fall, hr_rise, hr_fall;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              phase, phase_eff, r_lat, g_lat;
    logic              start, end_frame, pix_strobe, pix_done, pix_keep;

    cam_edge_det #(.RESET_VAL(1'b1)) u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (cam_pclk_en),
        .sig    (cam_vsync),
        .rise   (vs_rise),
        .fall   (vs_fall)
    );

    cam_edge_det #(.RESET_VAL(1'b0)) u_hr_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (cam_pclk_en),
        .sig    (cam_href),
        .rise   (hr_rise),
        .fall   (hr_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_VS;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        end_frame  = 1'b0;
        pix_strobe = 1'b0;
        case (state)
            WAIT_VS: if (vs_rise) state_nx = SYNC;
            SYNC: begin
                if (vs_fall && capture_en) begin
                    state_nx = ACTIVE;
                    start    = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_nx  = SYNC;
                    end_frame = 1'b1;
                end else begin
                    pix_strobe = cam_pclk_en & cam_href;
                end
            end
            default: state_nx = WAIT_VS;
        endcase
        // A line always opens on a high byte, whatever phase was left behind
        phase_eff = phase & ~hr_rise;
        pix_done  = pix_strobe & phase_eff;
        pix_keep  = pix_done & ~col[0] & ~row[0] & (col < COL_LIM) & (row < ROW_LIM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            phase      <= 1'b0;
            r_lat      <= 1'b0;
            g_lat      <= 1'b0;
        end else begin
            wr_en      <= pix_keep;
            frame_done <= end_frame;
            if (end_frame && (row != ROW_LIM)) begin
                frame_err <= 1'b1;
            end
            if (pix_keep) begin
                wr_addr <= addr;
                wr_data <= {r_lat, g_lat, cam_data[B_BIT]};
                addr    <= addr + 1'b1;
            end
            if (start) begin
                col   <= '0;
                row   <= '0;
                addr  <= '0;
                phase <= 1'b0;
            end else if (pix_strobe) begin
                if (!phase_eff) begin
                    r_lat <= cam_data[R_BIT];
                    g_lat <= cam_data[G_BIT];
                    phase <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (col != '1) col <= col + 1'b1;
                end
            end else if (state == ACTIVE && hr_fall && !vs_rise) begin
                if (row != '1) row <= row + 1'b1;
                col   <= '0;
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture on a reduced 16x12 source frame.
module tb_cam_capture;

    localparam int W   = 16;
    localparam int H   = 12;
    localparam int AW  = 6;
    localparam int FBW = W / 2;
    localparam int FULL = FBW * (H / 2);

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_en;
    logic          cam_pclk_en;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;
    logic          frame_done;
    logic          frame_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  g_cnt = 0;
    bit  exp_err = 1'b0;

    cam_capture #(.SRC_W(W), .SRC_H(H), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .capture_en  (capture_en),
        .cam_pclk_en (cam_pclk_en),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (frame_done === 1'b1) done_cnt++;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (wr_data === 3'b010) g_cnt++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic strobe(input logic v, input logic h, input logic [7:0] d);
        cam_vsync   = v;
        cam_href    = h;
        cam_data    = d;
        cam_pclk_en = 1'b1;
        @(posedge clk);
        #1;
        cam_pclk_en = 1'b0;
    endtask

    // mode 0: all red, 1: one green pixel at (2,2) with odd neighbours lit, 2: random
    task automatic frame(input bit cap, input int mode, input int lines,
                         input int wide_row, input int wide_cols);
        int          a;
        int          cols;
        logic [15:0] p;
        wr_t         e;
        a = 0;
        strobe(1'b0, 1'b0, 8'h00);
        strobe(1'b1, 1'b0, 8'h00);
        strobe(1'b1, 1'b0, 8'h00);
        capture_en = cap;
        strobe(1'b0, 1'b0, 8'h00);
        capture_en = 1'b0;
        strobe(1'b0, 1'b0, 8'h00);
        for (int r = 0; r < lines; r++) begin
            cols = (r == wide_row) ? wide_cols : W;
            for (int c = 0; c < cols; c++) begin
                case (mode)
                    0: p = 16'hF800;
                    1: p = (c == 2 && r == 2) ? 16'h07E0 :
                           ((c == 3 && r == 2) || (c == 2 && r == 3)) ? 16'hFFFF : 16'h0000;
                    default: p = 16'($urandom);
                endcase
                if (cap && (r % 2 == 0) && (c % 2 == 0) && c < W && r < H) begin
                    e.addr = AW'(a);
                    e.data = {p[15], p[10], p[4]};
                    exp_q.push_back(e);
                    a++;
                end
                strobe(1'b0, 1'b1, p[15:8]);
                strobe(1'b0, 1'b1, p[7:0]);
            end
            strobe(1'b0, 1'b0, 8'h00);
            strobe(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic vs_end(input bit partial);
        if (partial) begin
            strobe(1'b0, 1'b1, 8'hFF);
            strobe(1'b1, 1'b1, 8'hFF);
        end
        strobe(1'b1, 1'b0, 8'h00);
        strobe(1'b1, 1'b0, 8'h00);
    endtask

    task automatic check_frame(input string tag, input int w0, input int d0,
                               input int exp_wr, input int exp_done);
        chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
        chk({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
        chk({tag, "_err"}, 32'(frame_err), 32'(exp_err));
        chk({tag, "_q_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        int  w0, d0, g0;
        wr_t e;
        reset       = 1'b1;
        capture_en  = 1'b0;
        cam_pclk_en = 1'b0;
        cam_vsync   = 1'b0;
        cam_href    = 1'b0;
        cam_data    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        reset = 1'b0;

        // full red frame
        w0 = wr_cnt; d0 = done_cnt;
        frame(1'b1, 0, H, -1, 0);
        vs_end(1'b0);
        check_frame("red", w0, d0, FULL, 1);

        // single green pixel at (2,2) -> addr FBW+1
        w0 = wr_cnt; d0 = done_cnt; g0 = g_cnt;
        frame(1'b1, 1, H, -1, 0);
        vs_end(1'b0);
        check_frame("green", w0, d0, FULL, 1);
        chk("green_count", 32'(g_cnt - g0), 32'd1);

        // capture disabled at the first fall, enabled at the next
        w0 = wr_cnt; d0 = done_cnt;
        frame(1'b0, 2, H, -1, 0);
        vs_end(1'b0);
        check_frame("skip", w0, d0, 0, 0);
        w0 = wr_cnt; d0 = done_cnt;
        frame(1'b1, 2, H, -1, 0);
        vs_end(1'b0);
        check_frame("after_skip", w0, d0, FULL, 1);

        // short frame ending mid-pixel: error is sticky through a good frame
        w0 = wr_cnt; d0 = done_cnt;
        frame(1'b1, 2, H - 2, -1, 0);
        vs_end(1'b1);
        exp_err = 1'b1;
        check_frame("short", w0, d0, FBW * ((H - 2) / 2), 1);
        w0 = wr_cnt; d0 = done_cnt;
        frame(1'b1, 0, H, -1, 0);
        vs_end(1'b0);
        check_frame("sticky", w0, d0, FULL, 1);

        // one over-long line
        w0 = wr_cnt; d0 = done_cnt;
        frame(1'b1, 2, H, 2, W + 6);
        vs_end(1'b0);
        check_frame("wide", w0, d0, FULL, 1);

        // reset in the write cycle mid-frame
        w0 = wr_cnt;
        frame(1'b1, 0, 6, -1, 0);
        e.addr = AW'(FBW * 3);
        e.data = 3'b100;
        exp_q.push_back(e);
        strobe(1'b0, 1'b1, 8'hF8);
        strobe(1'b0, 1'b1, 8'h00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        chk("midrst_writes", 32'(wr_cnt - w0), 32'(FBW * 3 + 1));
        reset   = 1'b0;
        exp_err = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        frame(1'b1, 2, H, -1, 0);
        vs_end(1'b0);
        check_frame("post_rst", w0, d0, FULL, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
